// File: rtl/procesador_multiciclo_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcodes, ALU op codes,
// FSM state encodings and the funct3/funct7 ALU decoder.
package procesador_multiciclo_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    // sub only ever comes from funct7[5] on R-type; I-type passes 0.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic sub);
        alu_op_t op;
        case (funct3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/procesador_multiciclo_regfile.sv
// Register file: 2 asynchronous read ports, 1 synchronous write port, x0 reads as zero.
// Not reset; a same-edge read of the written register sees the old value.
module regfile_2r1w #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);

    logic [XLEN-1:0] regs [0:(2**REG_ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we && (waddr != '0))
            regs[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/procesador_multiciclo.sv
// Multi-cycle RV32I-subset core with one shared ALU and a single req/ready memory port.
// Optional macro RETIRE_CNT_EN adds the 32-bit retire_cnt output.
module procesador_multiciclo
    import procesador_multiciclo_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              REG_ADDR_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            halted,
    output logic [3:0]      state_dbg
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]     retire_cnt
`endif
);

    state_t          state, state_nxt;
    logic            run;
    logic [XLEN-1:0] pc, old_pc, ir, a, b, alu_out, data;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic [XLEN-1:0] rs1_data, rs2_data, rf_wdata;
    alu_op_t         alu_op;
    logic [6:0]      opcode;
    logic            xfer, rf_we;

    assign opcode = ir[6:0];
    assign imm_i  = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_s  = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // run stays low through the reset cycle so the port is idle while reset is applied
    assign mem_req   = run && (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE);
    assign mem_we    = run && (state == S_MEMWRITE);
    assign mem_addr  = (state == S_FETCH) ? pc : alu_out;
    assign mem_wdata = b;
    assign xfer      = mem_req && mem_ready;
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

    assign rf_we    = (state == S_MEMWB) || (state == S_ALUWB);
    assign rf_wdata = (state == S_MEMWB) ? data : alu_out;

    regfile_2r1w #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_regfile (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (ir[7 +: REG_ADDR_W]),
        .wdata  (rf_wdata),
        .raddr1 (ir[15 +: REG_ADDR_W]),
        .raddr2 (ir[20 +: REG_ADDR_W]),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_comb begin
        alu_a  = a;
        alu_b  = b;
        alu_op = ALU_ADD;
        case (state)
            S_DECODE: begin alu_a = old_pc; alu_b = imm_b; end
            S_MEMADR: alu_b = (opcode == OP_SW) ? imm_s : imm_i;
            S_EXECR:  alu_op = alu_decode(ir[14:12], ir[30]);
            S_EXECI:  begin alu_b = imm_i; alu_op = alu_decode(ir[14:12], 1'b0); end
            S_JAL:    begin alu_a = old_pc; alu_b = imm_j; end
            default:  ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (xfer) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
                    default:      state_nxt = S_HALT;
                endcase
            end
            S_MEMADR:   state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (xfer) state_nxt = S_MEMWB;
            S_MEMWRITE: if (xfer) state_nxt = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: state_nxt = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_nxt = S_FETCH;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_FETCH;
            run     <= 1'b0;
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            data    <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            case (state)
                S_FETCH: if (xfer) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                    pc     <= pc + XLEN'(4);
                end
                S_DECODE: begin
                    a       <= rs1_data;
                    b       <= rs2_data;
                    alu_out <= alu_y;
                end
                S_MEMADR, S_EXECR, S_EXECI: alu_out <= alu_y;
                S_MEMREAD: if (xfer) data <= mem_rdata;
                S_JAL: begin
                    pc      <= alu_y;
                    alu_out <= old_pc + XLEN'(4);
                end
                S_BEQ: if (a == b) pc <= alu_out;
                default: ;
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            retire_cnt <= '0;
        else if (state_nxt == S_FETCH && (state == S_MEMWB || state == S_MEMWRITE ||
                                          state == S_ALUWB || state == S_BEQ))
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule
